// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, ROM request issue, output FIFO
module fetch_ctrl #(
   parameter int             NPC      = 6,
   parameter int             NINST    = 32,
   parameter logic [NPC-1:0] RESET_PC = '0,
   parameter int             DEPTH    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_halt,
   input  logic             i_redirect,
   input  logic [NPC-1:0]   i_redirect_pc,
   output logic             o_mem_ce,
   output logic [NPC-1:0]   o_mem_addr,
   input  logic [NINST-1:0] i_mem_inst,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [NINST-1:0] o_inst,
   output logic [NPC-1:0]   o_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [NPC-1:0]   pc;
   logic [NPC-1:0]   inflight_pc;
   logic             inflight;
   logic [NINST-1:0] fifo_inst [DEPTH];
   logic [NPC-1:0]   fifo_pc   [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [CW:0]      occupancy;
   logic             pop;
   logic             push;
   logic             issue;

   always_comb begin
      pop       = o_valid & i_ready;
      push      = inflight & ~i_redirect;
      // Slots already spoken for, counting the response still on its way from the ROM.
      occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
      issue     = (state == S_RUN) && !i_halt && !i_redirect && (occupancy < DEPTH_W);

      // BOOT, RUN and HALT all leave on the same rule: halt selects HALT, otherwise RUN.
      state_nxt = state;
      case (state)
         S_BOOT:  state_nxt = i_halt ? S_HALT : S_RUN;
         S_RUN:   state_nxt = i_halt ? S_HALT : S_RUN;
         S_HALT:  state_nxt = i_halt ? S_HALT : S_RUN;
         default: state_nxt = S_BOOT;
      endcase

      o_mem_ce   = issue;
      o_mem_addr = pc;
      o_valid    = (count != '0);
      o_inst     = o_valid ? fifo_inst[rd_ptr] : '0;
      o_pc       = o_valid ? fifo_pc[rd_ptr]   : '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_BOOT;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (issue) inflight_pc <= pc;

         if (i_redirect)  pc <= i_redirect_pc;
         else if (issue)  pc <= pc + NPC'(1);

         // Redirect empties the queue; any handshake this cycle is simply dropped with it.
         if (i_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && push) begin
         fifo_inst[wr_ptr] <= i_mem_inst;
         fifo_pc[wr_ptr]   <= inflight_pc;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed bench for fetch_ctrl with a synchronous ROM model
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt = 1'b0;
   logic        redirect = 1'b0;
   logic [5:0]  redirect_pc = '0;
   logic        mem_ce;
   logic [5:0]  mem_addr;
   logic [31:0] mem_inst = '0;
   logic        valid;
   logic        ready = 1'b1;
   logic [31:0] inst;
   logic [5:0]  pc_out;

   int vectors = 0;
   int miscompares = 0;
   int count_viol = 0;
   int exp_pc;

   fetch_ctrl #(.NPC(6), .NINST(32), .RESET_PC(6'd0), .DEPTH(2)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_halt        (halt),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_mem_ce      (mem_ce),
      .o_mem_addr    (mem_addr),
      .i_mem_inst    (mem_inst),
      .o_valid       (valid),
      .i_ready       (ready),
      .o_inst        (inst),
      .o_pc          (pc_out)
   );

   initial forever #5 clk = ~clk;

   // ROM[k] = k + 100, one cycle read latency
   always @(posedge clk) begin
      if (mem_ce) mem_inst <= 32'd100 + 32'(mem_addr);
   end

   always @(negedge clk) begin
      if (!rst && (dut.count > 2)) begin
         count_viol++;
         $display("FAIL count_bound count=%0d max=2", dut.count);
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
      step;
      step;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      do_reset;
      vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b want=0", valid); end
      vectors++; if (mem_ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce got=%0b want=0", mem_ce); end
      vectors++; if (mem_addr !== 6'd0) begin miscompares++; $display("FAIL reset_addr got=%0h want=0", mem_addr); end
      vectors++; if (inst !== 32'd0) begin miscompares++; $display("FAIL reset_inst got=%0h want=0", inst); end
      vectors++; if (pc_out !== 6'd0) begin miscompares++; $display("FAIL reset_pc got=%0h want=0", pc_out); end
   endtask

   task automatic test_startup;
      do_reset;
      for (int c = 1; c <= 10; c++) begin
         step;
         #1;
         vectors++;
         if (mem_ce !== 1'b1 || mem_addr !== 6'(c-1)) begin
            miscompares++;
            $display("FAIL startup_issue c=%0d got ce=%0b addr=%0h want ce=1 addr=%0h", c, mem_ce, mem_addr, 6'(c-1));
         end
         vectors++;
         if (c >= 3) begin
            if (valid !== 1'b1 || pc_out !== 6'(c-3) || inst !== 32'(100+c-3)) begin
               miscompares++;
               $display("FAIL startup_out c=%0d got v=%0b pc=%0h inst=%0d want v=1 pc=%0h inst=%0d",
                        c, valid, pc_out, inst, 6'(c-3), 100+c-3);
            end
         end else if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL startup_early c=%0d got v=%0b want v=0", c, valid);
         end
      end
   endtask

   task automatic test_backpressure;
      do_reset;
      exp_pc = 0;
      for (int c = 1; c <= 14; c++) begin
         step;
         ready = !(c >= 3 && c <= 7);
         #1;
         if (c >= 3 && c <= 7) begin
            vectors++;
            if (valid !== 1'b1 || inst !== 32'd100 || pc_out !== 6'd0 || mem_ce !== 1'b0) begin
               miscompares++;
               $display("FAIL bp_hold c=%0d got v=%0b inst=%0d pc=%0h ce=%0b want v=1 inst=100 pc=0 ce=0",
                        c, valid, inst, pc_out, mem_ce);
            end
         end
         if (c == 5) begin
            vectors++;
            if (dut.count !== 2'd2) begin miscompares++; $display("FAIL bp_full got=%0d want=2", dut.count); end
         end
         if (valid && ready) begin
            vectors++;
            if (pc_out !== 6'(exp_pc) || inst !== 32'(100+exp_pc)) begin
               miscompares++;
               $display("FAIL bp_seq c=%0d got pc=%0h inst=%0d want pc=%0h inst=%0d", c, pc_out, inst, exp_pc, 100+exp_pc);
            end
            exp_pc++;
         end
      end
      vectors++;
      if (exp_pc != 7) begin miscompares++; $display("FAIL bp_count got=%0d want=7", exp_pc); end
   endtask

   task automatic test_redirect;
      do_reset;
      for (int c = 1; c <= 9; c++) begin
         step;
         ready = (c != 4);
         redirect = (c == 4);
         redirect_pc = 6'h20;
         #1;
         if (c == 4) begin
            vectors++;
            if (mem_ce !== 1'b0) begin miscompares++; $display("FAIL redir_noissue got=%0b want=0", mem_ce); end
         end
         if (c == 5) begin
            vectors++;
            if (mem_ce !== 1'b1 || mem_addr !== 6'h20) begin
               miscompares++;
               $display("FAIL redir_target got ce=%0b addr=%0h want ce=1 addr=20", mem_ce, mem_addr);
            end
         end
         if (c == 5 || c == 6) begin
            vectors++;
            if (valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush c=%0d got v=%0b want 0", c, valid); end
         end
         if (c == 7 || c == 8) begin
            vectors++;
            if (valid !== 1'b1 || pc_out !== 6'(32+c-7) || inst !== 32'(132+c-7)) begin
               miscompares++;
               $display("FAIL redir_out c=%0d got v=%0b pc=%0h inst=%0d want v=1 pc=%0h inst=%0d",
                        c, valid, pc_out, inst, 6'(32+c-7), 132+c-7);
            end
         end
      end
      redirect = 1'b0;
   endtask

   task automatic test_wrap;
      logic [5:0] ep;
      do_reset;
      for (int c = 1; c <= 10; c++) begin
         step;
         ready = 1'b1;
         redirect = (c == 4);
         redirect_pc = 6'h3E;
         #1;
         if (c >= 7) begin
            ep = 6'h3E + 6'(c-7);
            vectors++;
            if (valid !== 1'b1 || pc_out !== ep || inst !== 32'd100 + 32'(ep)) begin
               miscompares++;
               $display("FAIL wrap c=%0d got v=%0b pc=%0h inst=%0d want v=1 pc=%0h inst=%0d",
                        c, valid, pc_out, inst, ep, 100+int'(ep));
            end
         end
      end
      redirect = 1'b0;
   endtask

   task automatic test_halt;
      do_reset;
      exp_pc = 0;
      for (int c = 1; c <= 16; c++) begin
         step;
         halt = (c >= 6 && c <= 9);
         ready = 1'b1;
         #1;
         if (c >= 6 && c <= 9) begin
            vectors++;
            if (mem_ce !== 1'b0) begin miscompares++; $display("FAIL halt_ce c=%0d got=%0b want=0", c, mem_ce); end
         end
         if (c == 11) begin
            vectors++;
            if (mem_ce !== 1'b1 || mem_addr !== 6'd5) begin
               miscompares++;
               $display("FAIL halt_resume got ce=%0b addr=%0h want ce=1 addr=5", mem_ce, mem_addr);
            end
         end
         if (valid && ready) begin
            vectors++;
            if (pc_out !== 6'(exp_pc) || inst !== 32'(100+exp_pc)) begin
               miscompares++;
               $display("FAIL halt_seq c=%0d got pc=%0h inst=%0d want pc=%0h inst=%0d", c, pc_out, inst, exp_pc, 100+exp_pc);
            end
            exp_pc++;
         end
      end
      halt = 1'b0;
      vectors++;
      if (exp_pc != 9) begin miscompares++; $display("FAIL halt_count got=%0d want=9", exp_pc); end
   endtask

   task automatic test_midreset;
      do_reset;
      for (int c = 1; c <= 11; c++) begin
         step;
         ready = !(c >= 3 && c <= 5);
         rst = (c == 6);
         #1;
         if (c == 5) begin
            vectors++;
            if (dut.count !== 2'd2 || mem_ce !== 1'b0) begin
               miscompares++;
               $display("FAIL mr_full got count=%0d ce=%0b want count=2 ce=0", dut.count, mem_ce);
            end
         end
         if (c == 6) begin
            vectors++;
            if (mem_ce !== 1'b1 || mem_addr !== 6'd2) begin
               miscompares++;
               $display("FAIL mr_inflight got ce=%0b addr=%0h want ce=1 addr=2", mem_ce, mem_addr);
            end
         end
         if (c == 7) begin
            vectors++;
            if (valid !== 1'b0 || pc_out !== 6'd0 || inst !== 32'd0 || mem_ce !== 1'b0) begin
               miscompares++;
               $display("FAIL mr_cleared got v=%0b pc=%0h inst=%0d ce=%0b want all 0", valid, pc_out, inst, mem_ce);
            end
         end
         if (c == 8 || c == 9) begin
            vectors++;
            if (valid !== 1'b0) begin miscompares++; $display("FAIL mr_stale c=%0d got v=%0b want 0", c, valid); end
         end
         if (c == 8) begin
            vectors++;
            if (mem_ce !== 1'b1 || mem_addr !== 6'd0) begin
               miscompares++;
               $display("FAIL mr_restart got ce=%0b addr=%0h want ce=1 addr=0", mem_ce, mem_addr);
            end
         end
         if (c >= 10) begin
            vectors++;
            if (valid !== 1'b1 || pc_out !== 6'(c-10) || inst !== 32'(100+c-10)) begin
               miscompares++;
               $display("FAIL mr_out c=%0d got v=%0b pc=%0h inst=%0d want v=1 pc=%0h inst=%0d",
                        c, valid, pc_out, inst, 6'(c-10), 100+c-10);
            end
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_count_bound;
      vectors++;
      if (count_viol !== 0) begin
         miscompares++;
         $display("FAIL count_bound_total got=%0d want=0", count_viol);
      end
   endtask

   initial begin
      test_reset;
      test_startup;
      test_backpressure;
      test_redirect;
      test_wrap;
      test_halt;
      test_midreset;
      test_count_bound;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
